// File: rtl/mips_cpu_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_muldiv_ctrl
// Description : Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//               32-iteration shift-add multiply / restoring divide + fixup.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_muldiv_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_run   = 2'd1;
    localparam logic [1:0] c_fixup = 2'd2;

    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    logic        r_busy;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_dbz;
    logic [31:0] r_rs_raw;
    logic [31:0] r_opnd;
    logic [63:0] r_acc;

    // Operand magnitudes and sign flags, used only on the accept edge
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;

    assign w_a_neg = op[0] & rs_val[31];
    assign w_b_neg = op[0] & rt_val[31];
    assign w_a_mag = w_a_neg ? (32'd0 - rs_val) : rs_val;
    assign w_b_mag = w_b_neg ? (32'd0 - rt_val) : rt_val;

    // Multiply: acc = {partial product, remaining multiplier bits}
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opnd : 32'd0)};
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide: acc = {remainder, dividend bits shifting into quotient}
    logic [32:0] w_div_hi;
    logic        w_div_ge;
    logic [31:0] w_div_trial;
    logic [63:0] w_div_next;

    assign w_div_hi    = r_acc[63:31];
    assign w_div_ge    = (w_div_hi >= {1'b0, r_opnd});
    assign w_div_trial = r_acc[62:31] - r_opnd;
    assign w_div_next  = w_div_ge ? {w_div_trial, r_acc[30:0], 1'b1}
                                  : {r_acc[62:31], r_acc[30:0], 1'b0};

    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_prod = r_neg_res ? (64'd0 - r_acc) : r_acc;
    assign w_quot = r_neg_res ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem  = r_neg_rem ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_idle;
            r_cnt     <= 6'd0;
            r_busy    <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dbz     <= 1'b0;
            r_rs_raw  <= 32'd0;
            r_opnd    <= 32'd0;
            r_acc     <= 64'd0;
        end else if (clk_enable) begin
            case (r_state)
                c_idle: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_state   <= c_run;
                        r_busy    <= 1'b1;
                        r_cnt     <= 6'd0;
                        r_is_div  <= op[1];
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_dbz     <= op[1] & (rt_val == 32'd0);
                        r_rs_raw  <= rs_val;
                        // Multiply keeps the multiplier in acc; divide keeps the dividend
                        r_opnd    <= op[1] ? w_b_mag : w_a_mag;
                        r_acc     <= {32'd0, (op[1] ? w_a_mag : w_b_mag)};
                    end
                end
                c_run: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) r_state <= c_fixup;
                end
                c_fixup: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                    if (!r_is_div) begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end else if (r_dbz) begin
                        r_hi <= r_rs_raw;
                        r_lo <= 32'hFFFF_FFFF;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire
